unified_mem_arbiter: RTL and testbench
======================================

Name: unified_mem_arbiter

Overview:
Parametrised successor to the split instruction/data memory adapter. It serves an instruction channel (I) and a data channel (D) from one shared single-port memory array using a req/ready handshake, and adds programmable access latency, byte-enable writes, range checking and selectable arbitration. It sits between the CPU fetch/load-store stages and on-chip memory.

Parameters:
DATA_W, 32, data width in bits; must be a multiple of 8.
ADDR_W, 7, word-address width.
DEPTH, 128, number of implemented words; must satisfy DEPTH <= 2**ADDR_W.
RD_LAT, 2, read latency in access cycles; range 1..15.
WR_LAT, 1, write latency in access cycles; range 1..15.
ARB_RR, 0, arbitration mode; 0 = fixed priority with D first, 1 = round-robin.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
i_req  in  1  I-channel request; held stable until i_ready.
i_we  in  DATA_W/8  I-channel byte write enables; any nonzero value means write.
i_addr  in  ADDR_W  I-channel word address.
i_wdata  in  DATA_W  I-channel write data.
i_rdata  out  DATA_W  I-channel read data; valid while i_ready is high and held afterwards.
i_ready  out  1  I-channel one-cycle completion pulse.
i_err  out  1  I-channel out-of-range flag; pulses together with i_ready.
d_req, d_we, d_addr, d_wdata, d_rdata, d_ready, d_err  same widths and meanings for the D channel.
busy  out  1  high while the FSM is not in IDLE.

Behaviour:
- Reset: rst is asynchronous and active-high; clk is the clock.
  - State goes to IDLE and the latency counter to 0.
  - All outputs reset to 0: i_ready, d_ready, i_err, d_err, busy, i_rdata, d_rdata.
  - last_grant resets to I, so the first tie under round-robin goes to D.
  - The memory array is not reset; its contents persist.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - Requests are sampled only in this state.
  - At edge E0 with any req high, the FSM picks a winner.
  - It latches the winner's channel id, we, addr and wdata, and loads the counter with (write ? WR_LAT : RD_LAT).
  - It then moves to ACCESS and sets busy.
- Arbitration:
  - ARB_RR=0: D wins whenever d_req is high.
  - ARB_RR=1: with both requesting, the channel opposite last_grant wins. last_grant updates at each grant.
  - With a single requester, that requester always wins.
- Range check: latched addr >= DEPTH means out of range.
  - Write: the array is not modified.
  - Read: rdata for that channel becomes 0.
  - err pulses together with ready.
- ACCESS:
  - Write: enabled bytes are written at edge E0+1. Disabled bytes keep their old value.
  - Read: the array is read at edge E0+1 and pipelined internally. Data reaches the channel rdata register at edge E0+RD_LAT.
  - The counter decrements each edge. At the edge where it reaches 0 (E0+LAT), the FSM moves to DONE and asserts the granted channel's ready (and err if out of range).
  - Ready is therefore visible during the cycle after E0+LAT.
- DONE:
  - Ready is high for exactly one cycle. The FSM returns to IDLE and busy clears at the next edge.
  - req is ignored in DONE. This removes any double-issue when a requester drops req one cycle after seeing ready.
- Throughput: one access per LAT+2 cycles. The non-granted channel waits with its req held; nothing is dropped.
- rdata:
  - Written only on read completion of the owning channel.
  - Writes leave that channel's rdata unchanged.
  - The other channel's rdata is never disturbed.
- Read-after-write: a read granted after a write completes returns the new data. There is no internal bypass, because accesses are serialised.
- Changing req/addr/we while waiting (before ready) is a protocol violation with undefined result. The bench asserts that these inputs stay stable.
- Reset mid-operation:
  - The access is aborted and no ready is issued.
  - A write aborted before edge E0+1 is not committed.

Decomposition:
- Shared package: state encoding (IDLE/ACCESS/DONE), channel id constants CH_I/CH_D, and a clog2 function for counter width.
- One sub-module, mem_sp_be: a single-port byte-enable synchronous RAM (DEPTH x DATA_W) with a configurable output pipeline of RD_LAT-1 stages. It has no reset on the array.

Test Plan:
- Defaults. D reads addr 5 holding 0x12345678 → d_ready pulses 3 cycles after the request edge with d_rdata=0x12345678. i_ready stays 0.
- D writes 0xAABBCCDD to addr 9 with we=4'b1111, then writes 0x00000011 with we=4'b0001. A read of addr 9 then returns 0xAABBCC11. Each write gives d_ready 2 cycles after its grant.
- ARB_RR=0, i_req and d_req raised together for 3 accesses each → all D accesses complete first, then I. No request is lost.
- ARB_RR=1, both channels requesting continuously → grants alternate D,I,D,I, with ready pulses spaced RD_LAT+2 cycles apart.
- DEPTH=100: I reads addr 120 → i_ready with i_err=1 and i_rdata=0. A write to addr 120 leaves words 0..99 unchanged.
- rst asserted in ACCESS during a D write before edge E0+1 → all outputs 0 immediately. The target word keeps its old value, and a fresh read after reset works normally.

Source files
------------

// File: rtl/unified_mem_arbiter_pkg.sv
// unified_mem_arbiter_pkg: shared types and helpers for the unified I/D memory arbiter.
//   state_e    : arbiter FSM states (IDLE, ACCESS, DONE)
//   CH_I, CH_D : channel ids; CH_D = 1 so a lone d_req maps directly onto the winner id
//   MAX_LAT    : largest supported access latency
//   clog2      : ceiling log2, used to size the latency counter and RAM index
package unified_mem_arbiter_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

    localparam logic CH_I = 1'b0;
    localparam logic CH_D = 1'b1;
    localparam int MAX_LAT = 15;

    function automatic int clog2(input int v);
        int r = 0;
        for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// unified_mem_arbiter_if: I and D channel req/ready buses plus the busy status.
//   master : CPU side, drives req/we/addr/wdata and receives rdata/ready/err/busy
//   slave  : arbiter side, the mirror image of master
interface unified_mem_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 7
);
    logic                  i_req;
    logic [DATA_W/8-1:0]   i_we;
    logic [ADDR_W-1:0]     i_addr;
    logic [DATA_W-1:0]     i_wdata;
    logic [DATA_W-1:0]     i_rdata;
    logic                  i_ready;
    logic                  i_err;
    logic                  d_req;
    logic [DATA_W/8-1:0]   d_we;
    logic [ADDR_W-1:0]     d_addr;
    logic [DATA_W-1:0]     d_wdata;
    logic [DATA_W-1:0]     d_rdata;
    logic                  d_ready;
    logic                  d_err;
    logic                  busy;

    modport master (
        output i_req, i_we, i_addr, i_wdata, d_req, d_we, d_addr, d_wdata,
        input  i_rdata, i_ready, i_err, d_rdata, d_ready, d_err, busy
    );

    modport slave (
        input  i_req, i_we, i_addr, i_wdata, d_req, d_we, d_addr, d_wdata,
        output i_rdata, i_ready, i_err, d_rdata, d_ready, d_err, busy
    );

endinterface

// File: rtl/unified_mem_arbiter_mem_sp_be.sv
// mem_sp_be: single-port byte-enable RAM (DEPTH x DATA_W) with RD_LAT-1 output stages.
//   clk     : clock
//   we_i    : byte write enables, written at the rising edge
//   addr_i  : word address; addresses >= DEPTH never write and read as 0
//   wdata_i : write data
//   rdata_o : read data, RD_LAT-1 edges after addr_i is presented
// The array and the output pipeline carry no reset.
module mem_sp_be
    import unified_mem_arbiter_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 7,
    parameter int DEPTH  = 128,
    parameter int RD_LAT = 2
) (
    input  logic                clk,
    input  logic [DATA_W/8-1:0] we_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    output logic [DATA_W-1:0]   rdata_o
);

    localparam int NB = DATA_W / 8;
    localparam int IW = (DEPTH > 1) ? clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] LIM = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [IW-1:0]     idx;
    logic              in_range;
    logic [DATA_W-1:0] rd;

    assign idx      = IW'(addr_i);
    assign in_range = {1'b0, addr_i} < LIM;
    assign rd       = in_range ? mem_q[idx] : '0;

    always_ff @(posedge clk) begin
        for (int b = 0; b < NB; b++) if (in_range && we_i[b]) mem_q[idx][8*b +: 8] <= wdata_i[8*b +: 8];
    end

    // The owner's rdata register is the last of the RD_LAT read stages, so
    // only RD_LAT-1 of them live here; RD_LAT = 1 is a plain combinational read.
    if (RD_LAT == 1) begin : g_comb
        assign rdata_o = rd;
    end else begin : g_pipe
        logic [DATA_W-1:0] pipe_q [RD_LAT-1];
        always_ff @(posedge clk) begin
            pipe_q[0] <= rd;
            for (int s = 1; s < RD_LAT - 1; s++) pipe_q[s] <= pipe_q[s-1];
        end
        assign rdata_o = pipe_q[RD_LAT-2];
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: serves the I and D channels from one shared single-port RAM.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : slave side of unified_mem_arbiter_if (I/D req, we, addr, wdata in;
//         rdata, ready, err, busy out)
// One access at a time: IDLE grants, ACCESS counts the latency, DONE holds the
// ready pulse for one cycle while requests are ignored.
module unified_mem_arbiter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 7,
    parameter int DEPTH  = 128,
    parameter int RD_LAT = 2,
    parameter int WR_LAT = 1,
    parameter int ARB_RR = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    unified_mem_arbiter_if.slave   bus
);

    localparam int NB = DATA_W / 8;
    localparam int CW = clog2(MAX_LAT + 1);
    localparam logic [ADDR_W:0] LIM = (ADDR_W + 1)'(DEPTH);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              ch_q, ch_d;
    logic              last_q, last_d;
    logic              first_q, first_d;
    logic [NB-1:0]     we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              i_ready_q, i_ready_d, d_ready_q, d_ready_d;
    logic              i_err_q, i_err_d, d_err_q, d_err_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;

    logic              win;
    logic              wr;
    logic              in_range;
    logic [NB-1:0]     mem_we;
    logic [DATA_W-1:0] mem_rdata;

    // Ties go to D in fixed mode, or away from the previous grant in round-robin.
    assign win      = (bus.i_req && bus.d_req) ? ((ARB_RR != 0) ? ~last_q : CH_D)
                                               : (bus.d_req ? CH_D : CH_I);
    assign wr       = |we_q;
    assign in_range = {1'b0, addr_q} < LIM;
    // first_q marks the first ACCESS edge, the only one on which a write commits.
    assign mem_we   = (first_q && wr && in_range) ? we_q : '0;

    mem_sp_be #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .RD_LAT (RD_LAT)
    ) u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .addr_i  (addr_q),
        .wdata_i (wdata_q),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ch_d      = ch_q;
        last_d    = last_q;
        first_d   = 1'b0;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        i_ready_d = 1'b0;
        d_ready_d = 1'b0;
        i_err_d   = 1'b0;
        d_err_d   = 1'b0;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        case (state_q)
            IDLE: if (bus.i_req || bus.d_req) begin
                ch_d    = win;
                last_d  = win;
                first_d = 1'b1;
                we_d    = (win == CH_D) ? bus.d_we    : bus.i_we;
                addr_d  = (win == CH_D) ? bus.d_addr  : bus.i_addr;
                wdata_d = (win == CH_D) ? bus.d_wdata : bus.i_wdata;
                cnt_d   = (|we_d) ? CW'(WR_LAT) : CW'(RD_LAT);
                state_d = ACCESS;
            end
            ACCESS: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d   = DONE;
                    i_ready_d = (ch_q == CH_I);
                    d_ready_d = (ch_q == CH_D);
                    i_err_d   = i_ready_d && !in_range;
                    d_err_d   = d_ready_d && !in_range;
                    i_rdata_d = (i_ready_d && !wr) ? (in_range ? mem_rdata : '0) : i_rdata_q;
                    d_rdata_d = (d_ready_d && !wr) ? (in_range ? mem_rdata : '0) : d_rdata_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ch_q      <= CH_I;
            last_q    <= CH_I;
            first_q   <= 1'b0;
            we_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            i_ready_q <= 1'b0;
            d_ready_q <= 1'b0;
            i_err_q   <= 1'b0;
            d_err_q   <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ch_q      <= ch_d;
            last_q    <= last_d;
            first_q   <= first_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            i_ready_q <= i_ready_d;
            d_ready_q <= d_ready_d;
            i_err_q   <= i_err_d;
            d_err_q   <= d_err_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign bus.i_ready = i_ready_q;
    assign bus.d_ready = d_ready_q;
    assign bus.i_err   = i_err_q;
    assign bus.d_err   = d_err_q;
    assign bus.i_rdata = i_rdata_q;
    assign bus.d_rdata = d_rdata_q;
    assign bus.busy    = (state_q != IDLE);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: two arbiters (index 0 fixed priority, 1 round-robin), DEPTH 100,
// checked every cycle against a transaction-level model of grants, latencies and memory.
module tb_unified_mem_arbiter;

    localparam int DW  = 32;
    localparam int AW  = 7;
    localparam int DEP = 100;
    localparam int NB  = 4;

    typedef struct packed {
        logic [NB-1:0] we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } op_t;

    typedef struct {
        bit            ch;
        bit            wr;
        bit            err;
        int            g;
        int            r;
        logic [DW-1:0] rd;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] i_req = '0;
    logic [1:0] d_req = '0;
    logic [1:0] i_ready, d_ready, i_err, d_err, busy;
    logic [NB-1:0] i_we [2];
    logic [NB-1:0] d_we [2];
    logic [AW-1:0] i_addr [2];
    logic [AW-1:0] d_addr [2];
    logic [DW-1:0] i_wdata [2];
    logic [DW-1:0] d_wdata [2];
    logic [DW-1:0] i_rdata [2];
    logic [DW-1:0] d_rdata [2];

    int cyc = 0;
    int ncmp = 0;
    int nfail = 0;
    op_t  qi[$];
    op_t  qd[$];
    exp_t xq[$];
    logic [DW-1:0] mdl [2][DEP];
    logic [DW-1:0] exp_rd [2][2];
    bit lastg [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : gi
        unified_mem_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
        unified_mem_arbiter #(
            .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .RD_LAT(2), .WR_LAT(1), .ARB_RR(g)
        ) dut (
            .clk(clk),
            .rst(rst),
            .bus(bus)
        );
        assign bus.i_req   = i_req[g];
        assign bus.i_we    = i_we[g];
        assign bus.i_addr  = i_addr[g];
        assign bus.i_wdata = i_wdata[g];
        assign bus.d_req   = d_req[g];
        assign bus.d_we    = d_we[g];
        assign bus.d_addr  = d_addr[g];
        assign bus.d_wdata = d_wdata[g];
        assign i_rdata[g]  = bus.i_rdata;
        assign i_ready[g]  = bus.i_ready;
        assign i_err[g]    = bus.i_err;
        assign d_rdata[g]  = bus.d_rdata;
        assign d_ready[g]  = bus.d_ready;
        assign d_err[g]    = bus.d_err;
        assign busy[g]     = bus.busy;
    end

    task automatic chk(input string tag, input logic [DW-1:0] o, input logic [DW-1:0] x);
        ncmp++;
        assert (o === x) else begin
            nfail++;
            $error("FAIL %s at cycle %0d: observed %h expected %h", tag, cyc, o, x);
        end
    endtask

    task automatic chk_idle(input int k, input string tag);
        chk({tag, "_busy"},    DW'(busy[k]),    '0);
        chk({tag, "_i_ready"}, DW'(i_ready[k]), '0);
        chk({tag, "_d_ready"}, DW'(d_ready[k]), '0);
        chk({tag, "_i_err"},   DW'(i_err[k]),   '0);
        chk({tag, "_d_err"},   DW'(d_err[k]),   '0);
        chk({tag, "_i_rdata"}, i_rdata[k],      '0);
        chk({tag, "_d_rdata"}, d_rdata[k],      '0);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            lastg[k] = 1'b0;
            exp_rd[k][0] = '0;
            exp_rd[k][1] = '0;
        end
    endtask

    function automatic op_t rop();
        op_t o;
        o.addr  = AW'($urandom_range(0, 127));
        o.we    = ($urandom_range(0, 1) != 0) ? NB'($urandom_range(1, 15)) : '0;
        o.wdata = $urandom;
        return o;
    endfunction

    // Transaction model: one access at a time, LAT+2 cycles per access,
    // ready sampled LAT cycles after the grant edge.
    task automatic build(input int k, input int s);
        op_t qa[$];
        op_t qb[$];
        op_t o;
        exp_t e;
        int t;
        bit ch;
        qa = qi;
        qb = qd;
        t = s;
        xq.delete();
        while (qa.size() != 0 || qb.size() != 0) begin
            if (qa.size() != 0 && qb.size() != 0) ch = (k == 1) ? !lastg[k] : 1'b1;
            else ch = (qb.size() != 0);
            o = ch ? qb.pop_front() : qa.pop_front();
            e.ch  = ch;
            e.wr  = (o.we != 0);
            e.err = (int'(o.addr) >= DEP);
            e.g   = t;
            e.r   = t + (e.wr ? 1 : 2);
            e.rd  = '0;
            if (e.wr && !e.err)
                for (int b = 0; b < NB; b++) if (o.we[b]) mdl[k][o.addr][8*b +: 8] = o.wdata[8*b +: 8];
            if (!e.wr && !e.err) e.rd = mdl[k][o.addr];
            xq.push_back(e);
            lastg[k] = ch;
            t = e.r + 2;
        end
    endtask

    task automatic present(input int k);
        i_req[k] = (qi.size() != 0);
        d_req[k] = (qd.size() != 0);
        if (qi.size() != 0) begin
            i_we[k] = qi[0].we;
            i_addr[k] = qi[0].addr;
            i_wdata[k] = qi[0].wdata;
        end
        if (qd.size() != 0) begin
            d_we[k] = qd[0].we;
            d_addr[k] = qd[0].addr;
            d_wdata[k] = qd[0].wdata;
        end
    endtask

    task automatic run(input int k);
        exp_t e;
        int lim;
        bit pi, pd;
        @(negedge clk);
        build(k, cyc + 1);
        present(k);
        lim = cyc + 5 * xq.size() + 10;
        while (xq.size() != 0 && cyc < lim) begin
            @(negedge clk);
            e = xq[0];
            if (cyc == e.r && !e.wr) exp_rd[k][e.ch] = e.rd;
            chk("busy",    DW'(busy[k]),    DW'(cyc >= e.g && cyc <= e.r));
            chk("i_ready", DW'(i_ready[k]), DW'(cyc == e.r && !e.ch));
            chk("d_ready", DW'(d_ready[k]), DW'(cyc == e.r && e.ch));
            chk("i_err",   DW'(i_err[k]),   DW'(cyc == e.r && !e.ch && e.err));
            chk("d_err",   DW'(d_err[k]),   DW'(cyc == e.r && e.ch && e.err));
            chk("i_rdata", i_rdata[k], exp_rd[k][0]);
            chk("d_rdata", d_rdata[k], exp_rd[k][1]);
            pi = i_ready[k] && qi.size() != 0;
            pd = d_ready[k] && qd.size() != 0;
            if (pi) void'(qi.pop_front());
            if (pd) void'(qd.pop_front());
            if (pi || pd) present(k);
            if (cyc >= e.r + 1) void'(xq.pop_front());
        end
        chk("timeout", DW'(xq.size()), '0);
        qi.delete();
        qd.delete();
        xq.delete();
        i_req[k] = 1'b0;
        d_req[k] = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            i_we[k] = '0; i_addr[k] = '0; i_wdata[k] = '0;
            d_we[k] = '0; d_addr[k] = '0; d_wdata[k] = '0;
        end
        model_reset();
        repeat (2) @(negedge clk);
        chk_idle(0, "reset0");
        chk_idle(1, "reset1");
        rst = 1'b0;

        // Fill both memories so every later read has a known model value.
        for (int k = 0; k < 2; k++) begin
            for (int a = 0; a < DEP; a++) qd.push_back('{we: 4'hF, addr: AW'(a), wdata: $urandom});
            run(k);
        end

        // D read of a known word.
        qd.push_back('{we: 4'hF, addr: 7'd5, wdata: 32'h12345678});
        run(0);
        qd.push_back('{we: 4'h0, addr: 7'd5, wdata: 32'h0});
        run(0);
        chk("rd5_const", d_rdata[0], 32'h12345678);

        // Full write, partial byte write, read back.
        qd.push_back('{we: 4'hF, addr: 7'd9, wdata: 32'hAABBCCDD});
        qd.push_back('{we: 4'h1, addr: 7'd9, wdata: 32'h00000011});
        qd.push_back('{we: 4'h0, addr: 7'd9, wdata: 32'h0});
        run(0);
        chk("be_const", d_rdata[0], 32'hAABBCC11);

        // Both channels contending: fixed priority, then round-robin.
        for (int n = 0; n < 3; n++) begin
            qi.push_back(rop());
            qd.push_back(rop());
        end
        run(0);
        for (int n = 0; n < 3; n++) begin
            qi.push_back('{we: 4'h0, addr: AW'($urandom_range(0, DEP - 1)), wdata: 32'h0});
            qd.push_back('{we: 4'h0, addr: AW'($urandom_range(0, DEP - 1)), wdata: 32'h0});
        end
        run(1);

        // Out-of-range read and write.
        qi.push_back('{we: 4'h0, addr: 7'd120, wdata: 32'h0});
        run(0);
        chk("oor_rdata", i_rdata[0], '0);
        qd.push_back('{we: 4'hF, addr: 7'd120, wdata: $urandom});
        run(0);
        for (int a = 0; a < DEP; a++) qi.push_back('{we: 4'h0, addr: AW'(a), wdata: 32'h0});
        run(0);

        // Reset in ACCESS before the write commits.
        @(negedge clk);
        d_req[0] = 1'b1; d_we[0] = 4'hF; d_addr[0] = 7'd9; d_wdata[0] = 32'hDEADBEEF;
        @(posedge clk);
        #2;
        chk("abort_busy", DW'(busy[0]), DW'(1));
        d_req[0] = 1'b0;
        rst = 1'b1;
        #1;
        chk_idle(0, "abort");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        qd.push_back('{we: 4'h0, addr: 7'd9, wdata: 32'h0});
        run(0);
        chk("abort_const", d_rdata[0], 32'hAABBCC11);

        // Random mixed traffic on both arbiters.
        for (int r = 0; r < 12; r++) begin
            int k;
            k = $urandom_range(0, 1);
            for (int n = 0; n < int'($urandom_range(1, 4)); n++) qi.push_back(rop());
            for (int n = 0; n < int'($urandom_range(0, 4)); n++) qd.push_back(rop());
            run(k);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
